// File: rtl/vram_arbiter.sv
// Single-port text VRAM arbiter: one-word display cache plus an Avalon-MM CPU port.
// The display fetch normally wins; the CPU wins after MAX_CPU_WAIT stalled cycles.
module vram_arbiter #(
  parameter int WORDS        = 1200,
  parameter int ADDR_W       = 12,
  parameter int MAX_CPU_WAIT = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [31:0]       disp_data,
  output logic              disp_valid,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic [3:0]        cpu_byteenable,
  output logic              cpu_waitrequest,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_readdatavalid,
  output logic [ADDR_W-1:0] vram_addr,
  output logic              vram_we,
  output logic [3:0]        vram_be,
  output logic [31:0]       vram_wdata,
  input  logic [31:0]       vram_rdata
);

  localparam int SW = $clog2(MAX_CPU_WAIT + 1);
  localparam logic [SW-1:0]     STARVE_MAX = SW'(MAX_CPU_WAIT);
  localparam logic [ADDR_W-1:0] WORDS_A    = ADDR_W'(WORDS);

  function automatic logic [31:0] merge_lanes(input logic [31:0] base,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = base;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = wdata[8*i +: 8];
      else       res[8*i +: 8] = base[8*i +: 8];
    end
    return res;
  endfunction

  logic [ADDR_W-1:0] cache_addr_r;
  logic [31:0]       cache_data_r;
  logic              cache_valid_r;
  logic              disp_pending_r;
  logic [ADDR_W-1:0] pend_addr_r;
  logic              pend_oor_r;
  logic              cpu_pending_r;
  logic              cpu_oor_r;
  logic [SW-1:0]     starve_cnt_r;

  logic        disp_hit_s, disp_need_s, cpu_cmd_s;
  logic        cpu_grant_s, disp_grant_s;
  logic        cpu_in_range_s, disp_in_range_s, wr_commit_s;
  logic [31:0] fill_base_s, fill_data_s;

  assign disp_hit_s      = cache_valid_r & (cache_addr_r == disp_addr);
  assign disp_need_s     = disp_req & ~disp_hit_s & ~(disp_pending_r & (pend_addr_r == disp_addr));
  assign cpu_cmd_s       = cpu_read | cpu_write;
  assign cpu_in_range_s  = cpu_addr < WORDS_A;
  assign disp_in_range_s = disp_addr < WORDS_A;
  assign wr_commit_s     = cpu_grant_s & cpu_write & cpu_in_range_s;

  // Per-cycle grant: starved CPU beats the display, otherwise display first.
  always_comb begin
    cpu_grant_s  = 1'b0;
    disp_grant_s = 1'b0;
    if (Reset) begin
      cpu_grant_s  = 1'b0;
      disp_grant_s = 1'b0;
    end else if (cpu_cmd_s && (!disp_need_s || (starve_cnt_r == STARVE_MAX))) begin
      cpu_grant_s = 1'b1;
    end else if (disp_need_s) begin
      disp_grant_s = 1'b1;
    end else begin
      cpu_grant_s  = 1'b0;
      disp_grant_s = 1'b0;
    end
  end

  // VRAM port drive; out-of-range accesses leave the RAM idle.
  always_comb begin
    vram_addr  = {ADDR_W{1'b0}};
    vram_we    = 1'b0;
    vram_be    = 4'b0000;
    vram_wdata = 32'h0000_0000;
    if (wr_commit_s) begin
      vram_addr  = cpu_addr;
      vram_we    = 1'b1;
      vram_be    = cpu_byteenable;
      vram_wdata = cpu_wdata;
    end else if (cpu_grant_s && !cpu_write && cpu_in_range_s) begin
      vram_addr = cpu_addr;
    end else if (disp_grant_s && disp_in_range_s) begin
      vram_addr = disp_addr;
    end else begin
      vram_addr = {ADDR_W{1'b0}};
    end
  end

  // Fill word, with a same-edge CPU write to the fill address taking its lanes.
  always_comb begin
    fill_base_s = pend_oor_r ? 32'h0000_0000 : vram_rdata;
    if (wr_commit_s && (cpu_addr == pend_addr_r)) begin
      fill_data_s = merge_lanes(fill_base_s, cpu_wdata, cpu_byteenable);
    end else begin
      fill_data_s = fill_base_s;
    end
  end

  // Outstanding display fetch and CPU read.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      disp_pending_r <= 1'b0;
      pend_addr_r    <= {ADDR_W{1'b0}};
      pend_oor_r     <= 1'b0;
      cpu_pending_r  <= 1'b0;
      cpu_oor_r      <= 1'b0;
    end else begin
      disp_pending_r <= disp_grant_s;
      if (disp_grant_s) begin
        pend_addr_r <= disp_addr;
        pend_oor_r  <= ~disp_in_range_s;
      end
      cpu_pending_r <= cpu_grant_s & ~cpu_write;
      cpu_oor_r     <= ~cpu_in_range_s;
    end
  end

  // CPU starvation counter, saturating.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      starve_cnt_r <= {SW{1'b0}};
    end else if (cpu_grant_s) begin
      starve_cnt_r <= {SW{1'b0}};
    end else if (cpu_cmd_s && (starve_cnt_r != STARVE_MAX)) begin
      starve_cnt_r <= starve_cnt_r + SW'(1);
    end
  end

  // Display cache: fill from a completed fetch, or merge a CPU write hit.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cache_addr_r  <= {ADDR_W{1'b0}};
      cache_data_r  <= 32'h0000_0000;
      cache_valid_r <= 1'b0;
    end else if (disp_pending_r) begin
      cache_addr_r  <= pend_addr_r;
      cache_data_r  <= fill_data_s;
      cache_valid_r <= 1'b1;
    end else if (wr_commit_s && (cpu_addr == cache_addr_r)) begin
      cache_data_r <= merge_lanes(cache_data_r, cpu_wdata, cpu_byteenable);
    end
  end

  assign disp_valid        = disp_hit_s;
  assign disp_data         = cache_data_r;
  assign cpu_waitrequest   = Reset | (cpu_cmd_s & ~cpu_grant_s);
  // A read in flight when Reset arrives is dropped.
  assign cpu_readdatavalid = cpu_pending_r & ~Reset;
  assign cpu_rdata         = (cpu_pending_r & ~cpu_oor_r & ~Reset) ? vram_rdata : 32'h0000_0000;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: RAM model, golden-memory reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_vram_arbiter;
  localparam int WORDS = 1200;
  localparam int ADDR_W = 12;
  localparam int MAXW = 8;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic [31:0]       disp_data;
  logic              disp_valid;
  logic              cpu_read, cpu_write;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [3:0]        cpu_byteenable;
  logic              cpu_waitrequest;
  logic [31:0]       cpu_rdata;
  logic              cpu_readdatavalid;
  logic [ADDR_W-1:0] vram_addr;
  logic              vram_we;
  logic [3:0]        vram_be;
  logic [31:0]       vram_wdata;
  logic [31:0]       vram_rdata;

  always #10 Clk = ~Clk;

  vram_arbiter #(.WORDS(WORDS), .ADDR_W(ADDR_W), .MAX_CPU_WAIT(MAXW)) dut (
    .Clk(Clk), .Reset(Reset),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_data(disp_data), .disp_valid(disp_valid),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_byteenable(cpu_byteenable), .cpu_waitrequest(cpu_waitrequest), .cpu_rdata(cpu_rdata),
    .cpu_readdatavalid(cpu_readdatavalid),
    .vram_addr(vram_addr), .vram_we(vram_we), .vram_be(vram_be), .vram_wdata(vram_wdata),
    .vram_rdata(vram_rdata)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] b, input logic [31:0] w, input logic [3:0] be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? w[8*i +: 8] : b[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] init_val(input int i);
    case (i)
      5:       return 32'hBEEF_1234;
      7:       return 32'h7777_0007;
      9:       return 32'h9999_0009;
      default: return {16'(i) ^ 16'h3C5A, 16'(i * 7)};
    endcase
  endfunction

  // Synchronous single-port RAM behind the arbiter.
  logic [31:0] ram [0:WORDS-1];
  logic ram_ready = 1'b0;
  always @(posedge Clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < WORDS; i++) ram[i] <= init_val(i);
      ram_ready  <= 1'b1;
      vram_rdata <= 32'h0;
    end else if (int'(vram_addr) < WORDS) begin
      vram_rdata <= ram[vram_addr];
      if (vram_we) ram[vram_addr] <= merge(ram[vram_addr], vram_wdata, vram_be);
    end else begin
      vram_rdata <= 32'h0;
    end
  end

  // Reference model: golden memory contents plus what is cached / in flight.
  logic [31:0] gold [0:WORDS-1];
  logic gold_ready = 1'b0;
  logic model_on = 1'b0;
  logic m_c_valid = 1'b0, m_p_valid = 1'b0, m_rd_pend = 1'b0;
  int   m_c_addr = 0, m_p_addr = 0, m_starve = 0;
  logic [31:0] m_rd_data = 32'h0;
  logic d_reset = 1'b1, d_cpu_win = 1'b0, d_disp_win = 1'b0, d_cmd = 1'b0, d_wr = 1'b0;
  int   d_addr = 0, d_daddr = 0;
  logic [31:0] d_wdata = 32'h0;
  logic [3:0]  d_be = 4'h0;

  function automatic logic [31:0] gold_of(input int a);
    return (a < WORDS) ? gold[a] : 32'h0;
  endfunction

  logic e_dv, e_need, e_cmd, e_cw, e_dw, e_we, e_wait;
  int   e_vaddr;
  logic [3:0] e_be;

  always @(negedge Clk) begin
    if (model_on) begin
      e_dv   = m_c_valid && (m_c_addr == int'(disp_addr));
      e_need = disp_req && !e_dv && !(m_p_valid && (m_p_addr == int'(disp_addr)));
      e_cmd  = cpu_read || cpu_write;
      e_cw   = !Reset && e_cmd && (!e_need || (m_starve == MAXW));
      e_dw   = !Reset && e_need && !e_cw;
      e_wait = Reset || (e_cmd && !e_cw);
      e_we = 1'b0; e_be = 4'h0; e_vaddr = 0;
      if (e_cw && cpu_write && int'(cpu_addr) < WORDS) begin
        e_we = 1'b1; e_be = cpu_byteenable; e_vaddr = int'(cpu_addr);
      end else if (e_cw && !cpu_write && int'(cpu_addr) < WORDS) begin
        e_vaddr = int'(cpu_addr);
      end else if (e_dw && int'(disp_addr) < WORDS) begin
        e_vaddr = int'(disp_addr);
      end
      chk("waitrequest", 32'(cpu_waitrequest), 32'(e_wait));
      chk("vram_addr", 32'(vram_addr), 32'(e_vaddr));
      chk("vram_we", 32'(vram_we), 32'(e_we));
      chk("vram_be", 32'(vram_be), 32'(e_be));
      if (e_we) chk("vram_wdata", vram_wdata, cpu_wdata);
      chk("disp_valid", 32'(disp_valid), 32'(e_dv));
      chk("disp_data", disp_data, m_c_valid ? gold_of(m_c_addr) : 32'h0);
      chk("readdatavalid", 32'(cpu_readdatavalid), 32'(m_rd_pend && !Reset));
      chk("rdata", cpu_rdata, (m_rd_pend && !Reset) ? m_rd_data : 32'h0);
      d_reset = Reset; d_cpu_win = e_cw; d_disp_win = e_dw; d_cmd = e_cmd; d_wr = cpu_write;
      d_addr = int'(cpu_addr); d_daddr = int'(disp_addr); d_wdata = cpu_wdata; d_be = cpu_byteenable;
    end
  end

  always @(posedge Clk) begin
    if (!gold_ready) begin
      for (int i = 0; i < WORDS; i++) gold[i] <= init_val(i);
      gold_ready <= 1'b1;
    end else if (model_on) begin
      if (d_reset) begin
        m_c_valid <= 1'b0; m_c_addr <= 0; m_p_valid <= 1'b0; m_starve <= 0; m_rd_pend <= 1'b0;
      end else begin
        if (d_cpu_win && d_wr && d_addr < WORDS) gold[d_addr] <= merge(gold[d_addr], d_wdata, d_be);
        if (m_p_valid) begin
          m_c_valid <= 1'b1;
          m_c_addr  <= m_p_addr;
        end
        m_p_valid <= d_disp_win;
        m_p_addr  <= d_daddr;
        m_rd_pend <= d_cpu_win && !d_wr;
        m_rd_data <= gold_of(d_addr);
        m_starve  <= d_cpu_win ? 0 : (d_cmd ? ((m_starve < MAXW) ? m_starve + 1 : MAXW) : m_starve);
      end
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [ADDR_W-1:0] pick_addr();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 8)       return ADDR_W'($urandom_range(0, 15));
    else if (r == 8) return ADDR_W'($urandom_range(1190, 1210));
    else             return ADDR_W'($urandom_range(0, 4095));
  endfunction

  int waits;
  logic done;
  int hold;
  int kind;

  initial begin
    Reset = 1'b1; disp_req = 1'b0; disp_addr = '0;
    cpu_read = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = 32'h0; cpu_byteenable = 4'h0;
    step(); step();
    model_on = 1'b1;
    step();
    Reset = 1'b0;
    @(negedge Clk);
    chk("rst disp_valid", 32'(disp_valid), 32'h0);
    chk("rst disp_data", disp_data, 32'h0);
    chk("rst rdv", 32'(cpu_readdatavalid), 32'h0);
    chk("rst rdata", cpu_rdata, 32'h0);

    // Display fetch of word 5
    step(); disp_req = 1'b1; disp_addr = 12'd5;
    @(negedge Clk); chk("fetch5 addr", 32'(vram_addr), 32'd5);
    step();
    @(negedge Clk); chk("fetch5 idle", 32'(vram_addr), 32'd0);
    step();
    @(negedge Clk);
    chk("fetch5 valid", 32'(disp_valid), 32'h1);
    chk("fetch5 data", disp_data, 32'hBEEF_1234);

    // CPU write hitting the cached word
    step(); cpu_write = 1'b1; cpu_addr = 12'd5; cpu_wdata = 32'hAAAA_5555; cpu_byteenable = 4'b0011;
    @(negedge Clk);
    chk("wr5 we", 32'(vram_we), 32'h1);
    chk("wr5 wait", 32'(cpu_waitrequest), 32'h0);
    step(); cpu_write = 1'b0;
    @(negedge Clk);
    chk("wr5 we off", 32'(vram_we), 32'h0);
    chk("wr5 merged", disp_data, 32'hBEEF_5555);

    // CPU read starved by a display fetch every cycle
    step(); cpu_read = 1'b1; cpu_addr = 12'd7;
    waits = 0; done = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (!done) begin
        disp_addr = ADDR_W'(100 + k);
        @(negedge Clk);
        if (cpu_waitrequest) waits++;
        else done = 1'b1;
        step();
      end
    end
    cpu_read = 1'b0;
    chk("starve waits", 32'(waits), 32'd8);
    @(negedge Clk);
    chk("starve rdv", 32'(cpu_readdatavalid), 32'h1);
    chk("starve rdata", cpu_rdata, 32'h7777_0007);

    // Out-of-range CPU accesses
    step(); disp_req = 1'b0; cpu_read = 1'b1; cpu_addr = 12'd1200;
    @(negedge Clk);
    chk("oor rd wait", 32'(cpu_waitrequest), 32'h0);
    chk("oor rd addr", 32'(vram_addr), 32'h0);
    chk("oor rd we", 32'(vram_we), 32'h0);
    step(); cpu_read = 1'b0;
    @(negedge Clk);
    chk("oor rdv", 32'(cpu_readdatavalid), 32'h1);
    chk("oor rdata", cpu_rdata, 32'h0);
    step(); cpu_write = 1'b1; cpu_addr = 12'd4095; cpu_wdata = 32'hFFFF_FFFF; cpu_byteenable = 4'hF;
    @(negedge Clk);
    chk("oor wr we", 32'(vram_we), 32'h0);
    chk("oor wr wait", 32'(cpu_waitrequest), 32'h0);

    // Fill and write to the same word landing on the same edge
    step(); cpu_write = 1'b0; disp_req = 1'b1; disp_addr = 12'd9;
    @(negedge Clk); chk("coh fetch", 32'(vram_addr), 32'd9);
    step(); cpu_write = 1'b1; cpu_addr = 12'd9; cpu_wdata = 32'h5A00_0000; cpu_byteenable = 4'b1000;
    @(negedge Clk); chk("coh we", 32'(vram_we), 32'h1);
    step(); cpu_write = 1'b0;
    @(negedge Clk);
    chk("coh valid", 32'(disp_valid), 32'h1);
    chk("coh data", disp_data, 32'h5A99_0009);
    step(); cpu_read = 1'b1; cpu_addr = 12'd9;
    @(negedge Clk); chk("coh rd wait", 32'(cpu_waitrequest), 32'h0);
    step(); cpu_read = 1'b0;
    @(negedge Clk); chk("coh rdata", cpu_rdata, 32'h5A99_0009);

    // Reset right after a read is accepted
    step(); disp_req = 1'b0; cpu_read = 1'b1; cpu_addr = 12'd7;
    @(negedge Clk); chk("rstrd accept", 32'(cpu_waitrequest), 32'h0);
    step(); cpu_read = 1'b0; Reset = 1'b1;
    @(negedge Clk);
    chk("rstrd rdv", 32'(cpu_readdatavalid), 32'h0);
    chk("rstrd wait", 32'(cpu_waitrequest), 32'h1);
    step();
    @(negedge Clk);
    chk("rstrd dv", 32'(disp_valid), 32'h0);
    chk("rstrd dd", disp_data, 32'h0);
    chk("rstrd rdata", cpu_rdata, 32'h0);
    chk("rstrd rdv2", 32'(cpu_readdatavalid), 32'h0);
    step(); Reset = 1'b0;

    // Randomized traffic; commands are held until the model grants them
    hold = 0;
    for (int n = 0; n < 3000; n++) begin
      step();
      if (d_cpu_win) begin
        cpu_read = 1'b0; cpu_write = 1'b0;
      end
      Reset = ($urandom_range(0, 299) == 0);
      if (Reset) begin
        cpu_read = 1'b0; cpu_write = 1'b0;
      end else if (!cpu_read && !cpu_write && ($urandom_range(0, 2) == 0)) begin
        kind = int'($urandom_range(0, 6));
        cpu_read  = (kind < 3) || (kind == 6);
        cpu_write = (kind >= 3);
        cpu_addr = pick_addr();
        cpu_wdata = $urandom;
        cpu_byteenable = 4'($urandom_range(0, 15));
      end
      if (hold == 0) begin
        disp_req  = ($urandom_range(0, 3) != 0);
        disp_addr = pick_addr();
        hold = int'($urandom_range(0, 6));
      end else begin
        hold--;
      end
    end
    step(); Reset = 1'b0; cpu_read = 1'b0; cpu_write = 1'b0; disp_req = 1'b0;
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
